// File: rtl/v6502_pkg.sv
// v6502_pkg: shared fetch-stage types and constants for the 6502 core
package v6502_pkg;
  typedef enum logic [3:0] {RST, VEC_LO, VEC_HI, VEC_LD, OP, B1, B2, B3, HOLD} fetch_state_e;
  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
  localparam logic [7:0] BRK = 8'h00;
  localparam logic [7:0] RTI = 8'h40;
  localparam logic [7:0] RTS = 8'h60;
  localparam logic [7:0] JSR = 8'h20;
endpackage

// File: rtl/inst_len_predecode.sv
// inst_len_predecode: opcode byte to instruction length (1..3)
module inst_len_predecode
  import v6502_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [1:0] len_o
);
  logic [2:0] bbb;
  assign bbb = opcode_i[4:2];
  always_comb
    len_o = (opcode_i[3:0] == 4'h8 || opcode_i[3:0] == 4'hA ||
             opcode_i == BRK || opcode_i == RTI || opcode_i == RTS) ? LEN1 :
            (opcode_i == JSR || bbb == 3'b011 || bbb == 3'b111 ||
             (bbb == 3'b110 && opcode_i[1:0] == 2'b01)) ? LEN3 : LEN2;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: loads PC from the reset vector, fetches 1-3 byte instructions
// over a byte-wide port and hands them to the decoder via valid/ready.
module fetch_unit
  import v6502_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [15:0] inst_operand,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);
  fetch_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, ipc_q, ipc_d, opnd_q, opnd_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  len_q, len_d, pd_len;
  logic        valid_q, redir;

  inst_len_predecode u_pd (.opcode_i(mem_rdata), .len_o(pd_len));

  assign redir = redirect_valid && (state_q inside {OP, B1, B2, B3, HOLD});

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    len_d    = len_q;
    ipc_d    = ipc_q;
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    case (state_q)
      RST: state_d = VEC_LO;
      VEC_LO: begin
        mem_rd   = 1'b1;
        mem_addr = VECTOR_ADDR;
        state_d  = VEC_HI;
      end
      VEC_HI: begin
        mem_rd     = 1'b1;
        mem_addr   = VECTOR_ADDR + 16'd1;
        pc_d[7:0]  = mem_rdata;
        state_d    = VEC_LD;
      end
      VEC_LD: begin
        pc_d[15:8] = mem_rdata;
        state_d    = OP;
      end
      OP: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        state_d  = B1;
      end
      B1: begin
        op_d    = mem_rdata;
        ipc_d   = pc_q;
        len_d   = pd_len;
        opnd_d  = 16'h0000;
        mem_rd  = pd_len != LEN1;
        mem_addr = mem_rd ? pc_q + 16'd1 : 16'h0000;
        state_d = mem_rd ? B2 : HOLD;
      end
      B2: begin
        opnd_d[7:0] = mem_rdata;
        mem_rd      = len_q != LEN2;
        mem_addr    = mem_rd ? pc_q + 16'd2 : 16'h0000;
        state_d     = mem_rd ? B3 : HOLD;
      end
      B3: begin
        opnd_d[15:8] = mem_rdata;
        state_d      = HOLD;
      end
      HOLD: begin
        pc_d    = inst_ready ? pc_q + {14'd0, len_q} : pc_q;
        state_d = inst_ready ? OP : HOLD;
      end
      default: state_d = RST;
    endcase
    // a redirect drops everything gathered this cycle, including a pending handshake
    if (redir) begin
      state_d = OP;
      pc_d    = redirect_pc;
      op_d    = op_q;
      opnd_d  = opnd_q;
      len_d   = len_q;
      ipc_d   = ipc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      pc_q    <= 16'h0000;
      op_q    <= 8'h00;
      opnd_q  <= 16'h0000;
      len_q   <= 2'd0;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
      valid_q <= state_d == HOLD;
    end
  end

  assign inst_valid   = valid_q;
  assign inst_opcode  = op_q;
  assign inst_operand = opnd_q;
  assign inst_len     = len_q;
  assign inst_pc      = ipc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch stream plus scoreboard and corner sequences
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [15:0] inst_operand;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [7:0] mem [0:65535];

  typedef struct packed {logic [7:0] op; logic [7:0] b1; logic [7:0] b2; logic [1:0] len;} vec_t;
  typedef struct packed {logic [7:0] op; logic [15:0] opnd; logic [1:0] len; logic [15:0] pc;} bun_t;
  vec_t tbl [18];
  bun_t exp_q [$];
  int n_tests = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_opcode(inst_opcode),
    .inst_operand(inst_operand), .inst_len(inst_len), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [15:0] opnd, input logic [1:0] len, input logic [15:0] pc);
    bun_t b;
    b.op = op; b.opnd = opnd; b.len = len; b.pc = pc;
    exp_q.push_back(b);
  endtask

  task automatic mon();
    bun_t e;
    if (inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bundle: got op %h pc %h, required no bundle", inst_opcode, inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("bundle_opcode", {24'd0, inst_opcode}, {24'd0, e.op});
        chk("bundle_operand", {16'd0, inst_operand}, {16'd0, e.opnd});
        chk("bundle_len", {30'd0, inst_len}, {30'd0, e.len});
        chk("bundle_pc", {16'd0, inst_pc}, {16'd0, e.pc});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d bundles pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_addr(input string nm, input logic [15:0] a);
    int n = 0;
    while (!(mem_rd && mem_addr == a) && n < 50) begin
      step();
      n++;
    end
    chk(nm, {15'd0, mem_rd, mem_addr}, {16'h0001, a});
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!inst_valid && n < 50) begin
      step();
      n++;
    end
    chk(nm, {31'd0, inst_valid}, 32'd1);
  endtask

  initial begin
    logic [15:0] a, bp;
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h77;
    tbl = '{
      '{8'hEA, 8'h00, 8'h00, 2'd1}, '{8'hA9, 8'h05, 8'h00, 2'd2}, '{8'h8D, 8'h00, 8'h02, 2'd3},
      '{8'h00, 8'h00, 8'h00, 2'd1}, '{8'h40, 8'h00, 8'h00, 2'd1}, '{8'h60, 8'h00, 8'h00, 2'd1},
      '{8'h20, 8'h34, 8'h12, 2'd3}, '{8'h0A, 8'h00, 8'h00, 2'd1}, '{8'h4C, 8'h00, 8'h80, 2'd3},
      '{8'hB9, 8'h11, 8'h22, 2'd3}, '{8'h9E, 8'h33, 8'h44, 2'd3}, '{8'h81, 8'h55, 8'h00, 2'd2},
      '{8'hB1, 8'h66, 8'h00, 2'd2}, '{8'h18, 8'h00, 8'h00, 2'd1}, '{8'hBE, 8'h77, 8'h88, 2'd3},
      '{8'h96, 8'h99, 8'h00, 2'd2}, '{8'h7A, 8'h00, 8'h00, 2'd1}, '{8'h0C, 8'hAB, 8'hCD, 2'd3}};
    a = 16'h1234;
    for (int i = 0; i < 18; i++) begin
      mem[a] = tbl[i].op;
      if (tbl[i].len != 2'd1) mem[a + 16'd1] = tbl[i].b1;
      if (tbl[i].len == 2'd3) mem[a + 16'd2] = tbl[i].b2;
      push(tbl[i].op, tbl[i].len == 2'd1 ? 16'h0000 : tbl[i].len == 2'd2 ? {8'h00, tbl[i].b1} : {tbl[i].b2, tbl[i].b1}, tbl[i].len, a);
      a = a + {14'd0, tbl[i].len};
    end
    bp = a;
    mem[bp] = 8'hA5; mem[bp + 16'd1] = 8'h42;
    mem[bp + 16'd2] = 8'h8D; mem[bp + 16'd3] = 8'h00; mem[bp + 16'd4] = 8'h02;

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_fields", {inst_opcode, inst_operand, 6'd0, inst_len}, 32'd0);
    chk("rst_inst_pc", {16'd0, inst_pc}, 32'd0);

    rst_n = 1'b1;
    inst_ready = 1'b1;
    step(); chk("vec_lo_read", {15'd0, mem_rd, mem_addr}, 32'h0001FFFC);
    step(); chk("vec_hi_read", {15'd0, mem_rd, mem_addr}, 32'h0001FFFD);
    step(); chk("vec_ld_idle", {31'd0, mem_rd}, 32'd0);
    step(); chk("first_op_read", {15'd0, mem_rd, mem_addr}, 32'h00011234);
    drain("table_stream");

    inst_ready = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_hold_fields", {inst_opcode, inst_operand, 6'd0, inst_len}, {8'hA5, 16'h0042, 8'd2});
      chk("bp_hold_pc", {16'd0, inst_pc}, {16'd0, bp});
      chk("bp_hold_no_read", {31'd0, mem_rd}, 32'd0);
      step();
    end
    push(8'hA5, 16'h0042, 2'd2, bp);
    inst_ready = 1'b1;
    step(); chk("bp_next_op", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, bp + 16'd2});

    wait_addr("b2_read", bp + 16'd4);
    redirect_valid = 1'b1;
    redirect_pc = 16'h8000;
    step();
    redirect_valid = 1'b0;
    chk("redir_b2_op", {15'd0, mem_rd, mem_addr}, 32'h00018000);
    chk("redir_b2_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_b2_drop", exp_q.size(), 32'd0);
    inst_ready = 1'b0;
    wait_valid("redir_tgt_valid");
    chk("redir_tgt_fields", {inst_opcode, inst_operand, 6'd0, inst_len}, {8'hA9, 16'h0077, 8'd2});
    chk("redir_tgt_pc", {16'd0, inst_pc}, 32'h00008000);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_hold_op", {15'd0, mem_rd, mem_addr}, 32'h00018000);
    chk("redir_hold_valid", {31'd0, inst_valid}, 32'd0);
    push(8'hA9, 16'h0077, 2'd2, 16'h8000);
    drain("redir_refetch");
    inst_ready = 1'b0;

    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_op_read", {15'd0, mem_rd, mem_addr}, 32'h0001FFFE);
    push(8'h4C, 16'h1234, 2'd3, 16'hFFFE);
    inst_ready = 1'b1;
    wait_addr("wrap_hi_read", 16'h0000);
    drain("wrap_bundle");
    chk("wrap_next_pc", {15'd0, mem_rd, mem_addr}, 32'h00010001);
    inst_ready = 1'b0;

    redirect_valid = 1'b1;
    redirect_pc = 16'h1235;
    step();
    redirect_valid = 1'b0;
    wait_addr("mid_b1_read", 16'h1236);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst_pc", {16'd0, inst_pc}, 32'd0);
    step();
    rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h8000;
    step(); chk("rerun_vec_lo", {15'd0, mem_rd, mem_addr}, 32'h0001FFFC);
    step(); chk("rerun_vec_hi", {15'd0, mem_rd, mem_addr}, 32'h0001FFFD);
    step(); chk("rerun_vec_ld", {31'd0, mem_rd}, 32'd0);
    redirect_valid = 1'b0;
    step(); chk("rerun_first_op", {15'd0, mem_rd, mem_addr}, 32'h00011234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 6502 core, directly upstream of `prime_decoder`. After reset it loads the PC from the reset vector. It then fetches each instruction's opcode and 0–2 operand bytes over a byte-wide memory port and presents the assembled instruction to the decoder through a valid/ready handshake. It accepts PC redirects from execute (branch, jump).

## Interface
- `VECTOR_ADDR`, default 16'hFFFC: address of the reset-vector low byte; the high byte is at `VECTOR_ADDR+1`.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_addr` out 16: read address.
- `mem_rd` out 1: read strobe.
- `mem_rdata` in 8: read data, valid the cycle after `mem_rd`=1 (fixed 1-cycle latency, no wait states).
- `inst_valid` out 1: instruction bundle valid.
- `inst_ready` in 1: decoder accepts the bundle.
- `inst_opcode` out 8: opcode byte.
- `inst_operand` out 16: operand bytes {hi, lo}; unused bytes are 0.
- `inst_len` out 2: instruction length, 1..3.
- `inst_pc` out 16: address of the opcode.
- `redirect_valid` in 1: load a new PC.
- `redirect_pc` in 16: redirect target.

## Operation
- States: RST, VEC_LO, VEC_HI, VEC_LD, OP, B1, B2, B3, HOLD.
- **RST**: `mem_rd`=0, `mem_addr`=0. Unconditional transition to VEC_LO.
- **VEC_LO**: issue a read of `VECTOR_ADDR`.
- **VEC_HI**: issue a read of `VECTOR_ADDR+1`; capture `mem_rdata` as the low byte.
- **VEC_LD**: capture the high byte; pc={hi,lo}; go to OP.
- **OP**: issue a read of pc.
- **B1**: latch the opcode and `inst_pc`=pc; compute the length via predecode.
  - Length 1: go to HOLD with no read.
  - Otherwise: issue a read of pc+1 and go to B2.
- **B2**: latch the operand low byte.
  - Length 2: go to HOLD.
  - Otherwise: issue a read of pc+2 and go to B3.
- **B3**: latch the operand high byte; go to HOLD.
- **HOLD**: `inst_valid`=1 and all `inst_*` stable.
  - On `inst_ready`=1: pc ← pc+len, go to OP.
  - Otherwise: stay in HOLD.
- **Length predecode rules**, applied in priority order:
  - Low nibble 4'h8 or 4'hA → 1.
  - Opcode 8'h00, 8'h40 or 8'h60 → 1.
  - Opcode 8'h20 → 3.
  - bbb (bits 4:2) is 3'b011 or 3'b111 → 3.
  - bbb=3'b110 with cc (bits 1:0)=2'b01 → 3.
  - Everything else → 2.
- **Arithmetic**: all PC and address arithmetic is 16-bit modulo; FFFF+1=0000 and FFFE+2=0000.
- **Redirect**: `redirect_valid`=1 in any of OP, B1, B2, B3 or HOLD aborts the current fetch.
  - pc ← `redirect_pc`; next state is OP; `inst_valid` is 0 in the following cycle.
  - Redirect beats `inst_ready` in the same cycle: there is no pc+len update, and the bundle counts as dropped.
  - Redirect is ignored in RST and in the VEC_* states.
  - A read issued in the redirect cycle is discarded; its data is never latched.
- **Reset**: assertion of `rst_n` mid-operation returns the block to RST immediately, with outputs at their reset values. An in-flight read is discarded.

## Timing
- **Reset values**:
  - State RST, pc=0.
  - `mem_rd`=0, `mem_addr`=0.
  - `inst_valid`=0, `inst_opcode`=0, `inst_operand`=0, `inst_len`=0, `inst_pc`=0.
- **Start-up**: the first OP cycle is 4 cycles after reset release (RST, VEC_LO, VEC_HI, VEC_LD).
- **Latency** from entering OP to `inst_valid`=1:
  - 2 cycles for length 1.
  - 3 cycles for length 2.
  - 4 cycles for length 3.
- **Throughput**: with `inst_ready` held at 1, the next OP follows HOLD by one cycle. Peak rate is one instruction per 3/4/5 cycles for lengths 1/2/3.
- **Output registers**: `inst_*` are registered. `mem_addr` and `mem_rd` decode from state and pc.
- **Handshake**: `inst_valid` never drops without either a handshake or a redirect.

## Structure
- **Shared package** `v6502_pkg`:
  - Fetch state enum.
  - Length constants LEN1, LEN2, LEN3.
  - Default reset vector 16'hFFFC.
  - Opcode constants BRK, RTI, RTS and JSR.
- **Sub-module** `inst_len_predecode`: combinational, 8-bit opcode in, 2-bit length out. Shared with the decoder's length cross-check.

## Test plan
- **Reset vector**: memory has FFFC=34, FFFD=12 → first OP read at `mem_addr`=1234, issued 4 cycles after reset release.
- **Three lengths**: stream at 1234 = EA, A9 05, 8D 00 02 with `inst_ready`=1. Required bundles in order:
  - {EA, len 1, pc 1234}
  - {A9, 0005, len 2, pc 1235}
  - {8D, 0200, len 3, pc 1237}
- **Back-pressure**: hold `inst_ready`=0 for 5 cycles in HOLD → `inst_valid` stays 1 with stable fields; `mem_rd`=0 throughout; pc does not advance.
- **Redirect**: assert `redirect_valid` with `redirect_pc`=8000 during B2 of a 3-byte fetch → next cycle is OP with `mem_addr`=8000; no bundle from the aborted fetch; redirect concurrent with `inst_ready` in HOLD → fetch from 8000 with no pc+len applied.
- **Wrap-around**: 3-byte opcode 4C at FFFE → operand reads at FFFF and 0000; next pc is 0001.
- **Mid-fetch reset**: assert `rst_n`=0 during B1 → `mem_rd`=0 and `inst_valid`=0 immediately; after release the vector sequence repeats.
